// File: rtl/regfile.sv
// 32x32 register file with two bypassing read ports, a non-bypassing debug port
// and a wrapping count of committed writes. r0 is hardwired to zero and never stored.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [15:0] wr_count
);

  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic [31:0] regs_view [0:31];
  logic [15:0] wr_count_q;
  logic [15:0] wr_count_d;
  logic        commit;

  always_comb begin
    commit     = we && (waddr != 5'd0);
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (commit) begin
      wr_count_d = wr_count_q + 16'd1;
    end
    for (int i = 1; i < 32; i++) begin
      if (commit && (waddr == 5'(i))) begin
        regs_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Index-0 view of the array so every read port can use raddr directly.
  always_comb begin
    regs_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      regs_view[i] = regs_q[i];
    end
  end

  // Bypass returns the in-flight wdata so the value is stable across the commit edge.
  always_comb begin
    rdata1 = '0;
    if (!rst && (raddr1 != 5'd0) && re1) begin
      if (we && (waddr == raddr1)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs_view[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && (raddr2 != 5'd0) && re2) begin
      if (we && (waddr == raddr2)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs_view[raddr2];
      end
    end
  end

  always_comb begin
    dbg_data = '0;
    if (!rst) begin
      dbg_data = regs_view[dbg_addr];
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile.sv
// Directed, table-driven bench for regfile: vector table plus hand-written
// sequences for async reset, reset release and write-counter wrap.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [15:0] wr_count;

  int total;
  int bad;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [4:0]  dbg_addr;
    logic [31:0] exp_rdata1;
    logic [31:0] exp_rdata2;
    logic [31:0] exp_dbg;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [15];

  regfile dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input vec_t v);
    we       = v.we;
    waddr    = v.waddr;
    wdata    = v.wdata;
    re1      = v.re1;
    raddr1   = v.raddr1;
    re2      = v.re2;
    raddr2   = v.raddr2;
    dbg_addr = v.dbg_addr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic r1, input logic [4:0] a1,
                              input logic r2, input logic [4:0] a2, input logic [4:0] da,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] ed, input logic [15:0] ec);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd;
    v.re1 = r1; v.raddr1 = a1; v.re2 = r2; v.raddr2 = a2; v.dbg_addr = da;
    v.exp_rdata1 = e1; v.exp_rdata2 = e2; v.exp_dbg = ed; v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    total = 0;
    bad   = 0;

    // Expected values are the pre-edge combinational outputs for each vector.
    vecs[0]  = mk(1, 5,  32'h12345678, 0, 5,  0, 5,  5,  32'h0, 32'h0, 32'h0, 16'd0);
    vecs[1]  = mk(0, 5,  32'h0,        1, 5,  1, 5,  5,  32'h12345678, 32'h12345678, 32'h12345678, 16'd1);
    vecs[2]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,  1, 0,  0,  32'h0, 32'h0, 32'h0, 16'd1);
    vecs[3]  = mk(0, 0,  32'h0,        1, 0,  1, 0,  0,  32'h0, 32'h0, 32'h0, 16'd1);
    vecs[4]  = mk(1, 7,  32'h00000001, 0, 7,  0, 7,  7,  32'h0, 32'h0, 32'h0, 16'd1);
    vecs[5]  = mk(1, 7,  32'hA5A5A5A5, 1, 7,  1, 7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1, 16'd2);
    vecs[6]  = mk(0, 7,  32'h0,        1, 7,  1, 7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'd3);
    vecs[7]  = mk(1, 3,  32'hDEADBEEF, 0, 3,  0, 3,  3,  32'h0, 32'h0, 32'h0, 16'd3);
    vecs[8]  = mk(0, 3,  32'h0,        0, 3,  1, 3,  3,  32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 16'd4);
    vecs[9]  = mk(1, 9,  32'hCAFEF00D, 1, 9,  0, 9,  9,  32'hCAFEF00D, 32'h0, 32'h0, 16'd4);
    vecs[10] = mk(1, 9,  32'h11112222, 1, 3,  1, 9,  9,  32'hDEADBEEF, 32'h11112222, 32'hCAFEF00D, 16'd5);
    vecs[11] = mk(0, 9,  32'hFFFFFFFF, 1, 9,  1, 9,  9,  32'h11112222, 32'h11112222, 32'h11112222, 16'd6);
    vecs[12] = mk(0, 31, 32'h0,        1, 31, 1, 1,  31, 32'h0, 32'h0, 32'h0, 16'd6);
    vecs[13] = mk(1, 31, 32'h80000001, 1, 31, 0, 31, 31, 32'h80000001, 32'h0, 32'h0, 16'd6);
    vecs[14] = mk(0, 31, 32'h0,        1, 31, 1, 31, 31, 32'h80000001, 32'h80000001, 32'h80000001, 16'd7);

    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h99999999;
    re1 = 1'b1; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd4; dbg_addr = 5'd4;
    #2;
    checkOutput("reset_rdata1", rdata1, 32'h0);
    checkOutput("reset_rdata2", rdata2, 32'h0);
    checkOutput("reset_dbg", dbg_data, 32'h0);
    checkOutput("reset_wr_count", 32'(wr_count), 32'h0);
    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("post_reset_r4", rdata1, 32'h0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp_rdata1);
      checkOutput($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].exp_rdata2);
      checkOutput($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].exp_dbg);
      checkOutput($sformatf("vec%0d_wr_count", i), 32'(wr_count), 32'(vecs[i].exp_cnt));
    end

    // Async reset between edges, with a write pending while reset is held.
    @(negedge clk);
    we = 1'b1; waddr = 5'd10; wdata = 32'h55; re1 = 1'b0; re2 = 1'b0;
    @(negedge clk);
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd10; dbg_addr = 5'd10;
    #1;
    checkOutput("async_pre_rdata1", rdata1, 32'h55);
    checkOutput("async_pre_wr_count", 32'(wr_count), 32'd8);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rdata1_drop", rdata1, 32'h0);
    checkOutput("async_dbg_drop", dbg_data, 32'h0);
    checkOutput("async_wr_count_clear", 32'(wr_count), 32'h0);
    we = 1'b1; waddr = 5'd11; wdata = 32'h77; re2 = 1'b1; raddr2 = 5'd11;
    #1;
    checkOutput("async_no_bypass_in_rst", rdata2, 32'h0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0; dbg_addr = 5'd11;
    #1;
    checkOutput("release_r10", rdata1, 32'h0);
    checkOutput("release_r11", rdata2, 32'h0);
    checkOutput("release_dbg_r11", dbg_data, 32'h0);
    checkOutput("release_wr_count", 32'(wr_count), 32'h0);

    // First edge after release must commit.
    we = 1'b1; waddr = 5'd12; wdata = 32'h1234; dbg_addr = 5'd12;
    @(posedge clk);
    #1;
    checkOutput("resume_wr_count", 32'(wr_count), 32'd1);
    checkOutput("resume_dbg_r12", dbg_data, 32'h1234);

    // Counter wrap after 65536 committed writes.
    @(negedge clk);
    we = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    checkOutput("wrap_start", 32'(wr_count), 32'h0);
    we = 1'b1; waddr = 5'd1; wdata = 32'h0;
    repeat (65535) @(negedge clk);
    checkOutput("wrap_ffff", 32'(wr_count), 32'hFFFF);
    @(negedge clk);
    checkOutput("wrap_zero", 32'(wr_count), 32'h0);
    @(negedge clk);
    checkOutput("wrap_one", 32'(wr_count), 32'h1);
    we = 1'b0;
    @(negedge clk);
    checkOutput("no_write_hold", 32'(wr_count), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
